// File: rtl/gpio_in_ctrl_pkg.sv
// gpio_in_pkg: register offsets and default debounce length shared by the
// GPIO input controller and its debounce cells.
package gpio_in_pkg;

  localparam logic [11:0] ADDR_SW   = 12'h000;
  localparam logic [11:0] ADDR_BTN  = 12'h004;
  localparam logic [11:0] ADDR_EDGE = 12'h008;
  localparam logic [11:0] ADDR_MASK = 12'h00C;

  // 10 ms of stable input at 100 MHz
  localparam int DEB_CYCLES_DEF = 1000000;

  // True when the offset hits one of the four implemented registers
  function automatic logic is_mapped(input logic [11:0] off);
    return (off == ADDR_SW) || (off == ADDR_BTN) ||
           (off == ADDR_EDGE) || (off == ADDR_MASK);
  endfunction

endpackage

// File: rtl/gpio_in_ctrl_debounce.sv
// debounce_cell: one-bit 2-flop synchroniser followed by a stability counter.
// The stable level only follows the synced input after it has differed from
// the current level for DEB_CYCLES consecutive cycles; any return to the
// stable level restarts the count. rise_o is high in the cycle whose posedge
// moves the stable level from 0 to 1, so a register fed by it sets on the
// same edge as the level.
module debounce_cell #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic din_i,
  output logic level_o,
  output logic rise_o
);

  localparam int CNT_W = $clog2(DEB_CYCLES);

  logic             sync1_q;
  logic             sync2_q;
  logic             level_q;
  logic [CNT_W-1:0] cnt_q;
  logic             flip;

  // Counter has run out while the input still disagrees: adopt the input now
  assign flip    = (sync2_q != level_q) && (cnt_q == CNT_W'(DEB_CYCLES - 1));
  assign level_o = level_q;
  assign rise_o  = flip && !level_q;

  // Synchronise the raw input and track how long it has disagreed
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= din_i;
      sync2_q <= sync1_q;
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (flip) begin
        level_q <= sync2_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/gpio_in_ctrl.sv
// gpio_in_ctrl: memory-mapped switch/button input peripheral.
// Registers: SW (0x000), BTN (0x004), EDGE sticky rise flags with
// write-1-to-clear (0x008), MASK (0x00C). irq_o = registered |(EDGE & MASK).
// Build option: define SW_DEBOUNCE_EN to route switches through debounce
// cells as well; otherwise switches are only 2-flop synchronised.
module gpio_in_ctrl
  import gpio_in_pkg::*;
#(
  parameter int SW_W       = 16,
  parameter int BTN_N      = 5,
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic             CLK100,
  input  logic             resetn,
  input  logic             req_i,
  input  logic             we_i,
  input  logic [31:0]      addr_i,
  input  logic [31:0]      wdata_i,
  input  logic [SW_W-1:0]  SW,
  input  logic [BTN_N-1:0] btn_i,
  output logic [31:0]      rdata_o,
  output logic             ready_o,
  output logic             irq_o
);

  logic [11:0]      off;
  logic [SW_W-1:0]  sw_lvl;
  logic [BTN_N-1:0] btn_lvl;
  logic [BTN_N-1:0] btn_rise;
  logic [BTN_N-1:0] edge_q, edge_d;
  logic [BTN_N-1:0] mask_q, mask_d;
  logic [BTN_N-1:0] clr;
  logic [31:0]      rdata_q, rd_d;
  logic             ready_q;
  logic             irq_q;
  logic             unused_bits;

  assign off         = addr_i[11:0];
  assign unused_bits = ^{addr_i[31:12], wdata_i};

  for (genvar i = 0; i < BTN_N; i++) begin : g_btn
    debounce_cell #(.DEB_CYCLES(DEB_CYCLES)) u_btn (
      .clk_i  (CLK100),
      .rst_ni (resetn),
      .din_i  (btn_i[i]),
      .level_o(btn_lvl[i]),
      .rise_o (btn_rise[i])
    );
  end

`ifdef SW_DEBOUNCE_EN
  logic [SW_W-1:0] sw_rise_unused;

  for (genvar i = 0; i < SW_W; i++) begin : g_sw
    debounce_cell #(.DEB_CYCLES(DEB_CYCLES)) u_sw (
      .clk_i  (CLK100),
      .rst_ni (resetn),
      .din_i  (SW[i]),
      .level_o(sw_lvl[i]),
      .rise_o (sw_rise_unused[i])
    );
  end
`else
  logic [SW_W-1:0] sw_sync1_q, sw_sync2_q;

  // Plain 2-flop synchroniser for the switches
  always_ff @(posedge CLK100) begin
    if (!resetn) begin
      sw_sync1_q <= '0;
      sw_sync2_q <= '0;
    end else begin
      sw_sync1_q <= SW;
      sw_sync2_q <= sw_sync1_q;
    end
  end

  assign sw_lvl = sw_sync2_q;
`endif

  // Write decode, EDGE set/clear (set wins) and read mux from pre-edge state
  always_comb begin
    mask_d = mask_q;
    clr    = '0;
    if (req_i && we_i) begin
      if (off == ADDR_MASK) mask_d = wdata_i[BTN_N-1:0];
      if (off == ADDR_EDGE) clr    = wdata_i[BTN_N-1:0];
    end
    edge_d = (edge_q & ~clr) | btn_rise;

    rd_d = '0;
    if (is_mapped(off)) begin
      case (off)
        ADDR_SW:   rd_d = 32'(sw_lvl);
        ADDR_BTN:  rd_d = 32'(btn_lvl);
        ADDR_EDGE: rd_d = 32'(edge_q);
        default:   rd_d = 32'(mask_q);
      endcase
    end
  end

  // Register state, capture read data, pulse ready and register the irq
  always_ff @(posedge CLK100) begin
    if (!resetn) begin
      edge_q  <= '0;
      mask_q  <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      edge_q  <= edge_d;
      mask_q  <= mask_d;
      ready_q <= req_i;
      irq_q   <= |(edge_q & mask_q);
      if (req_i && !we_i) rdata_q <= rd_d;
    end
  end

  assign rdata_o = rdata_q;
  assign ready_o = ready_q;
  assign irq_o   = irq_q;

endmodule

// File: tb/tb_gpio_in_ctrl.sv
// Directed bench for gpio_in_ctrl with DEB_CYCLES = 4 (switch debounce off).
module tb_gpio_in_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req, we;
  logic [31:0] addr, wdata;
  logic [15:0] sw;
  logic [4:0]  btn;
  logic [31:0] rdata;
  logic        ready, irq;
  logic [31:0] d;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  gpio_in_ctrl #(.SW_W(16), .BTN_N(5), .DEB_CYCLES(4)) dut (
    .CLK100 (clk),
    .resetn (resetn),
    .req_i  (req),
    .we_i   (we),
    .addr_i (addr),
    .wdata_i(wdata),
    .SW     (sw),
    .btn_i  (btn),
    .rdata_o(rdata),
    .ready_o(ready),
    .irq_o  (irq)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Advance one posedge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] data);
    req  = 1'b1;
    we   = 1'b0;
    addr = a;
    tick();
    req  = 1'b0;
    data = rdata;
    check_eq("rd_ready", 32'(ready), 32'd1);
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] v);
    req   = 1'b1;
    we    = 1'b1;
    addr  = a;
    wdata = v;
    tick();
    req   = 1'b0;
    we    = 1'b0;
    check_eq("wr_ready", 32'(ready), 32'd1);
  endtask

  initial begin
    resetn = 1'b0;
    req = 1'b0; we = 1'b0; addr = '0; wdata = '0; sw = '0; btn = '0;
    repeat (3) tick();
    check_eq("rst_rdata", rdata, 32'd0);
    check_eq("rst_ready", 32'(ready), 32'd0);
    check_eq("rst_irq", 32'(irq), 32'd0);
    resetn = 1'b1;
    tick();

    // 1: idle reads after reset
    bus_read(32'h004, d); check_eq("btn_after_rst", d, 32'd0);
    tick();               check_eq("ready_pulse", 32'(ready), 32'd0);
    bus_read(32'h008, d); check_eq("edge_after_rst", d, 32'd0);
    check_eq("irq_after_rst", 32'(irq), 32'd0);

    // 2: switches visible two cycles after change, not one
    sw = 16'hA5C3;
    tick();
    bus_read(32'h000, d); check_eq("sw_early", d, 32'd0);
    bus_read(32'h000, d); check_eq("sw_value", d, 32'h0000A5C3);

    // 3: glitch on button 2 restarts the debounce count
    btn[2] = 1'b1; tick(); tick();
    btn[2] = 1'b0; tick(); tick();
    btn[2] = 1'b1;
    repeat (5) tick();
    bus_read(32'h004, d); check_eq("btn_glitch_early", d, 32'd0);
    bus_read(32'h004, d); check_eq("btn_glitch_rise", d, 32'h4);
    bus_read(32'h008, d); check_eq("edge_after_rise", d, 32'h4);
    bus_write(32'h008, 32'h4);
    bus_read(32'h008, d); check_eq("edge_w1c", d, 32'd0);
    btn[2] = 1'b0;
    repeat (8) tick();
    bus_read(32'h004, d); check_eq("btn_release", d, 32'd0);
    bus_read(32'h008, d); check_eq("edge_no_fall", d, 32'd0);

    // 4: masked interrupt timing
    bus_write(32'h00C, 32'h4);
    bus_read(32'h00C, d); check_eq("mask_rb", d, 32'h4);
    btn[2] = 1'b1;
    repeat (6) tick();
    check_eq("irq_latency", 32'(irq), 32'd0);
    tick();
    check_eq("irq_set", 32'(irq), 32'd1);
    bus_read(32'h008, d); check_eq("edge_btn2", d, 32'h4);
    bus_write(32'h008, 32'h4);
    check_eq("irq_clr_latency", 32'(irq), 32'd1);
    tick();
    check_eq("irq_cleared", 32'(irq), 32'd0);
    bus_read(32'h008, d); check_eq("edge_cleared", d, 32'd0);

    // 5: clear and set of EDGE bit 0 on the same edge -> set wins
    btn[0] = 1'b1;
    repeat (5) tick();
    bus_write(32'h008, 32'h1);
    bus_read(32'h008, d); check_eq("edge_set_wins", d, 32'h1);
    check_eq("irq_unmasked_bit", 32'(irq), 32'd0);
    bus_write(32'h008, 32'h0);
    bus_read(32'h008, d); check_eq("edge_write0", d, 32'h1);
    bus_write(32'h008, 32'h1);
    bus_read(32'h008, d); check_eq("edge_bit0_clr", d, 32'd0);

    // 6: unmapped offset, then reset during a request
    bus_read(32'h000, d); check_eq("sw_reload", d, 32'h0000A5C3);
    bus_read(32'h100, d); check_eq("unmapped_rd", d, 32'd0);
    bus_write(32'h100, 32'hFFFF_FFFF);
    bus_read(32'h00C, d); check_eq("mask_kept", d, 32'h4);
    bus_read(32'h004, d); check_eq("btn_both", d, 32'h5);

    req = 1'b1; we = 1'b0; addr = 32'h004;
    resetn = 1'b0; btn = '0; sw = '0;
    tick();
    req = 1'b0;
    check_eq("rst_drop_ready", 32'(ready), 32'd0);
    check_eq("rst_mid_rdata", rdata, 32'd0);
    check_eq("rst_mid_irq", 32'(irq), 32'd0);
    resetn = 1'b1;
    bus_read(32'h000, d); check_eq("rst_sw", d, 32'd0);
    bus_read(32'h004, d); check_eq("rst_btn", d, 32'd0);
    bus_read(32'h008, d); check_eq("rst_edge", d, 32'd0);
    bus_read(32'h00C, d); check_eq("rst_mask", d, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
